// File: rtl/adder_pkg.sv
// Shared constants for the adder stage and its downstream accumulator.
package adder_pkg;

  localparam int unsigned SAMPLE_W = 3;

  localparam logic [0:0] ACC_ST_ACCUM = 1'b0;
  localparam logic [0:0] ACC_ST_HOLD  = 1'b1;

  // Packs the adder outputs into one sample; value = {carry, sum}.
  function automatic logic [SAMPLE_W-1:0] make_sample(input logic carry, input logic [1:0] sum);
    return {carry, sum};
  endfunction

endpackage

// File: rtl/adder_result_accumulator_frame_counter.sv
// Per-frame sample counter with synchronous clear and a terminal flag
// that flags the count at which the next accept closes the frame.
module frame_counter #(
  parameter int unsigned N_SAMPLES = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  assign last = (count == CNT_W'(N_SAMPLES - 1));

  // Counter register; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adder_result_accumulator.sv
// Sums N_SAMPLES accepted {carry, sum} samples from the adder stage and
// presents each frame total on a valid/ready port with a sticky wrap flag.
module adder_result_accumulator
  import adder_pkg::*;
#(
  parameter  int unsigned ACC_W     = 8,
  parameter  int unsigned N_SAMPLES = 16,
  localparam int unsigned CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_valid,
  input  logic             Carry_in,
  input  logic [1:0]       Sum_in,
  output logic             In_ready,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [ACC_W-1:0] Acc_out,
  output logic             Overflow,
  output logic [CNT_W-1:0] Count_out
);

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_last;
  logic [ACC_W:0]   add_full;

  // Both handshake outputs are pure decodes of the state flop.
  assign In_ready  = (state_q == ACC_ST_ACCUM);
  assign Out_valid = (state_q == ACC_ST_HOLD);
  assign Acc_out   = acc_q;
  assign Overflow  = ovf_q;

  assign accept   = In_valid & In_ready;
  assign add_full = {1'b0, acc_q} + (ACC_W + 1)'(make_sample(Carry_in, Sum_in));

  frame_counter #(
    .N_SAMPLES (N_SAMPLES),
    .CNT_W     (CNT_W)
  ) u_frame_counter (
    .clk   (Clk),
    .rst   (Rst),
    .clr   (cnt_clr),
    .inc   (accept),
    .count (Count_out),
    .last  (cnt_last)
  );

  // State, accumulator and overflow registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ACC_ST_ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: accumulate in ACCUM, hand off the frame in HOLD.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_clr = 1'b0;
    case (state_q)
      ACC_ST_ACCUM: begin
        if (accept) begin
          acc_d = add_full[ACC_W-1:0];
          ovf_d = ovf_q | add_full[ACC_W];
          if (cnt_last) begin
            state_d = ACC_ST_HOLD;
          end
        end
      end
      ACC_ST_HOLD: begin
        if (Out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_clr = 1'b1;
          state_d = ACC_ST_ACCUM;
        end
      end
      default: begin
        state_d = ACC_ST_ACCUM;
      end
    endcase
  end

endmodule
